// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: reset vector, branch counter type,
// counter encodings and the saturating counter update rule.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t SNT = 2'b00;
    localparam bht_ctr_t WNT = 2'b01;
    localparam bht_ctr_t WT  = 2'b10;
    localparam bht_ctr_t ST  = 2'b11;

    // Moves a 2-bit counter one step towards the resolved direction,
    // sticking at the strong states instead of wrapping around.
    function automatic bht_ctr_t ctrUpdate(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nextCtr;
        nextCtr = ctr;
        if (taken) begin
            if (ctr != ST) begin
                nextCtr = ctr + 2'd1;
            end
        end else begin
            if (ctr != SNT) begin
                nextCtr = ctr - 2'd1;
            end
        end
        return nextCtr;
    endfunction

endpackage

// File: rtl/fetch_predict_bht.sv
// Bimodal branch-history table: an array of 2-bit saturating counters with
// one combinational read port (fetch) and one synchronous update port
// (execute). A read and a write to the same entry in one cycle return the
// old counter; the trained value shows up on the following cycle.
module bht
    import riscv_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] i_rdIdx,
    output bht_ctr_t            o_rdCtr,
    input  logic                i_wrEn,
    input  logic [IDX_BITS-1:0] i_wrIdx,
    input  logic                i_wrTaken
);

    localparam int ENTRIES = 1 << IDX_BITS;

    bht_ctr_t r_table [ENTRIES];

    // Reinitialise every counter to weakly not-taken on reset, otherwise
    // train the addressed entry with the resolved branch direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= WNT;
            end
        end else if (i_wrEn) begin
            r_table[i_wrIdx] <= ctrUpdate(r_table[i_wrIdx], i_wrTaken);
        end
    end

    assign o_rdCtr = r_table[i_rdIdx];

endmodule

// File: rtl/fetch_predict.sv
// Instruction-fetch stage: owns the PC register, selects the next fetch
// address from reset / execute recovery / stall / decode redirect / PC+4,
// and looks up a taken prediction for the current PC in the BHT.
module fetch_predict
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        pc_predict_redirect_D,
    input  logic [31:0] predicted_target_pc_D,
    input  logic        mispredict_E,
    input  logic [31:0] correct_pc_E,
    input  logic        BranchE,
    input  logic        branch_taken_E,
    input  logic [31:0] PCE,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        predict_taken_F
);

    logic [31:0] r_pc;
    logic [31:0] w_pcPlus4;
    bht_ctr_t    w_fetchCtr;
    logic        w_unusedBits;

    assign w_pcPlus4 = r_pc + 32'd4;

    // Next-PC selection: execute recovery beats a stall, and a stall beats
    // the decode redirect. A redirect held off by a stall is not lost since
    // decode is stalled too and keeps asserting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (mispredict_E) begin
            r_pc <= correct_pc_E;
        end else if (StallF) begin
            r_pc <= r_pc;
        end else if (pc_predict_redirect_D) begin
            r_pc <= predicted_target_pc_D;
        end else begin
            r_pc <= w_pcPlus4;
        end
    end

    bht #(
        .IDX_BITS (IDX_BITS)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .i_rdIdx   (r_pc[IDX_BITS+1:2]),
        .o_rdCtr   (w_fetchCtr),
        .i_wrEn    (BranchE),
        .i_wrIdx   (PCE[IDX_BITS+1:2]),
        .i_wrTaken (branch_taken_E)
    );

    // Only the PC index bits and the counter MSB matter for prediction.
    assign w_unusedBits = ^{PCE[31:IDX_BITS+2], PCE[1:0], w_fetchCtr[0]};

    assign PCF             = r_pc;
    assign PCPlus4F        = w_pcPlus4;
    assign predict_taken_F = w_fetchCtr[1];

endmodule
